uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the memory-mapped I/O space: the receive-side counterpart of the UART transmitter. Deserialises 8N1 frames from the RX pin at 115200 baud off the 25 MHz system clock and presents the received byte in a 16-bit word the CPU reads. Bit 15 flags "no data". The CPU writes to the register to acknowledge the byte.

## Interface
- BAUD_DIV, 217: clock cycles per bit (25 MHz / 115200).
- HALF_DIV, BAUD_DIV/2 (108): cycles from the synchronised start edge to the start-bit sample point.
- clk  in  1  system clock, 25 MHz.
- CDONE  in  1  reset. Synchronous and active-low: low on a rising clk edge resets the block.
- RX  in  1  serial input, asynchronous to clk, idle high.
- clear  in  1  CPU write strobe. High for one cycle to acknowledge the byte and mark the register empty.
- out  out  16  read data:
  - bit 15 is 1 = empty.
  - bit 14 is the framing-error flag (see Configuration).
  - bits 7:0 are the received byte.
  - All other bits are always 0.

## Operation
- RX passes through a 2-flop synchroniser; rx_s is the synchroniser output. The register stage below adds no further delay.
- Registers:
  - 16-bit cycle counter cnt.
  - 4-bit bit index idx.
  - 8-bit shift register sh.
  - state.
- States:
  - IDLE: cnt=0. rx_s==0 → START.
  - START: cnt increments.
    - At cnt==HALF_DIV-1, sample rx_s.
    - rx_s==1 is a false start → IDLE.
    - rx_s==0 → DATA, with cnt=0 and idx=0.
  - DATA: cnt increments.
    - At cnt==BAUD_DIV-1, set sh <= {rx_s, sh[7:1]} (LSB first), idx+1, cnt=0.
    - After the 8th sample → STOP.
  - STOP: at cnt==BAUD_DIV-1, sample the stop bit.
    - Commit the byte (see below).
    - rx_s==1 → IDLE; rx_s==0 → BREAK.
  - BREAK: wait for rx_s==1, then → IDLE. This prevents a held-low line from retriggering.
- Commit on the STOP sample edge: out <= {1'b0, err, 6'b0, byte}.
- Overrun: a new commit overwrites an unread byte. No flag is raised.
- clear:
  - With no commit in the same cycle, out <= 16'h8000.
  - clear and commit in the same cycle: the commit wins.
  - clear while empty: no effect.
- The receiver runs independently of clear. Frames are accepted whether or not the register has been read.

## Timing
- Reset values:
  - out=16'h8000.
  - state=IDLE.
  - cnt=0, idx=0, sh=0.
  - Synchroniser flops = 1.
- A reset mid-frame abandons the frame. Nothing is committed.
- Cycle 0 is the first edge at which rx_s==0 in IDLE. Sample points:
  - start bit at cycle HALF_DIV (108).
  - data bit k (k=0..7) at 108+217·(k+1).
  - stop bit at 108+217·9 = 2061.
- out shows the byte after the edge at cycle 2061.
- Pin-to-rx_s latency is 2 cycles.
- A start glitch shorter than HALF_DIV cycles is rejected.
- Tolerated baud mismatch is about ±4%.

## Configuration
- UART_RX_FRAMING_ERR_EN defined:
  - A stop sample of 0 commits out <= 16'h4000: empty=0, err=1, data=0. The bad byte is discarded.
  - clear returns out to 16'h8000.
- UART_RX_FRAMING_ERR_EN undefined:
  - The stop bit is ignored for data purposes. The byte commits normally.
  - Bit 14 is tied to 0.
- BREAK handling is present in both builds.

## Structure
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, BREAK).
  - BAUD_DIV_DEFAULT=217.
  - the EMPTY=16'h8000 and FERR=16'h4000 constants. These are shared with the transmitter's status word.
- Sub-module sync2: a generic 2-flop synchroniser with reset value 1. It is reused for other async pins.

## Test plan
- Reset: CDONE=0 for 4 cycles, RX=1 → out==16'h8000; it stays there for 3000 idle cycles.
- Send 0x55 (bit time 217) → out==16'h0055 exactly 2 cycles + 2062 edges after the RX falling edge. It holds until a clear pulse, then reads 16'h8000.
- RX low for 50 cycles, then high → out unchanged (16'h8000). A valid 0xA3 frame sent afterwards → 16'h00A3.
- Back-to-back frames 0xA3 then 0x0F with no clear → out==16'h000F. Clear asserted on the 0x0F commit cycle → out==16'h000F.
- Stop bit driven 0, then RX released high. For byte 0x3C:
  - with UART_RX_FRAMING_ERR_EN, out==16'h4000.
  - without it, out==16'h003C.
  - Either way, the next valid frame 0x81 gives 16'h0081.
- CDONE pulsed low during data bit 3 → out==16'h8000. The partial frame is never committed. The following 0xFF frame gives 16'h00FF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, default baud divisor,
// and the status-word constants used by both the receiver and the transmitter.
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 217;

  localparam logic [15:0] EMPTY = 16'h8000;
  localparam logic [15:0] FERR  = 16'h4000;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t START = 3'd1;
  localparam state_t DATA  = 3'd2;
  localparam state_t STOP  = 3'd3;
  localparam state_t BREAK = 3'd4;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchroniser for asynchronous input pins; both stages reset
// to RST_VAL so an idle-high line reads as idle straight out of reset.
module sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver presenting a 16-bit CPU read word (bit 15 = empty).
// Build option UART_RX_FRAMING_ERR_EN: a bad stop bit commits 16'h4000 instead of the byte.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        CDONE,
  input  logic        RX,
  input  logic        clear,
  output logic [15:0] out
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  logic        rx_s;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [15:0] out_q, out_d;
  logic        commit;

  sync2 #(.W(1), .RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (CDONE),
    .d     (RX),
    .q     (rx_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == BAUD_LAST) begin
          sh_d  = {rx_s, sh_q[7:1]};
          idx_d = idx_q + 4'd1;
          cnt_d = '0;
          if (idx_q == 4'd7) state_d = STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == BAUD_LAST) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = rx_s ? IDLE : BREAK;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      BREAK: begin
        // A line held low after the frame must return high before a new start is seen.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_d = out_q;
    if (commit) begin
`ifdef UART_RX_FRAMING_ERR_EN
      out_d = rx_s ? {8'h00, sh_q} : FERR;
`else
      out_d = {8'h00, sh_q};
`endif
    end else if (clear) begin
      out_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!CDONE) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      out_q   <= EMPTY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are generated from byte values, expected
// read words and their appearance cycles are queued, and a monitor checks every change of out.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        CDONE;
  logic        RX;
  logic        clear;
  logic [15:0] out;

  always #20 clk = ~clk;

  uart_rx dut (
    .clk   (clk),
    .CDONE (CDONE),
    .RX    (RX),
    .clear (clear),
    .out   (out)
  );

  typedef struct {
    logic [15:0] word;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] model_out = 16'h8000;
  logic [15:0] prev_out = 16'h8000;
  bit          mon_en = 1'b0;

  // Edge-to-commit distance: 2 synchroniser edges, then cycles 0..2061.
  localparam int COMMIT_LAT = 2064;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] expected_word(input logic [7:0] b, input bit stop_ok);
`ifdef UART_RX_FRAMING_ERR_EN
    return stop_ok ? {8'h00, b} : 16'h4000;
`else
    return {8'h00, b};
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && (out !== prev_out)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_change: got %h expected %h", out, prev_out);
      end else begin
        e = exp_q.pop_front();
        check16("out_word", out, e.word);
        check_int("out_cycle", cyc, e.cyc);
      end
      prev_out = out;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int bt);
    logic [15:0] w;
    @(negedge clk);
    RX = 1'b0;
    w = expected_word(b, stop_ok);
    if (w !== model_out) exp_q.push_back('{word: w, cyc: cyc + COMMIT_LAT});
    model_out = w;
    repeat (bt) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      RX = b[k];
      repeat (bt) @(negedge clk);
    end
    RX = stop_ok;
    repeat (bt) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    if (model_out !== 16'h8000) exp_q.push_back('{word: 16'h8000, cyc: cyc + 1});
    model_out = 16'h8000;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic glitch(input int len);
    @(negedge clk);
    RX = 1'b0;
    repeat (len) @(negedge clk);
    RX = 1'b1;
  endtask

  // Frame whose data bit 3 is interrupted by a reset pulse; the line is released high at the reset.
  task automatic send_frame_reset_abort(input logic [7:0] b, input int bt);
    logic [9:0] lv;
    int         hit;
    lv  = {1'b1, b, 1'b0};
    hit = 4 * bt + 100;
    @(negedge clk);
    for (int t = 0; t < 10 * bt; t++) begin
      RX    = (t >= hit) ? 1'b1 : lv[t / bt];
      CDONE = !(t >= hit && t < hit + 4);
      @(negedge clk);
    end
    CDONE = 1'b1;
    RX    = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    int         bt;

    RX    = 1'b1;
    clear = 1'b0;
    CDONE = 1'b0;
    repeat (4) @(negedge clk);
    check16("reset_out", out, 16'h8000);
    CDONE   = 1'b1;
    prev_out = out;
    mon_en  = 1'b1;
    idle(3000);
    check16("idle_hold", out, 16'h8000);

    send_frame(8'h55, 1'b1, 217);
    idle(300);
    check16("hold_55", out, 16'h0055);
    pulse_clear();
    idle(2);
    check16("clear_empty", out, 16'h8000);

    glitch(50);
    idle(200);
    check16("glitch_reject", out, 16'h8000);
    send_frame(8'hA3, 1'b1, 217);
    idle(300);
    check16("after_glitch", out, 16'h00A3);
    pulse_clear();

    send_frame(8'hA3, 1'b1, 217);
    fork
      send_frame(8'h0F, 1'b1, 217);
      begin
        @(negedge clk);
        repeat (COMMIT_LAT - 1) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
    join
    idle(300);
    check16("b2b_clear_on_commit", out, 16'h000F);
    pulse_clear();

    send_frame(8'h3C, 1'b0, 217);
    idle(300);
    check16("bad_stop", out, expected_word(8'h3C, 1'b0));
    send_frame(8'h81, 1'b1, 217);
    idle(300);
    check16("after_bad_stop", out, 16'h0081);
    pulse_clear();

    send_frame_reset_abort(8'h5A, 217);
    idle(300);
    check16("reset_abort", out, 16'h8000);
    send_frame(8'hFF, 1'b1, 217);
    idle(300);
    check16("after_reset_abort", out, 16'h00FF);
    pulse_clear();

    for (int i = 0; i < 20; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 3) != 0);
      bt = $urandom_range(212, 222);
      send_frame(b, ok, bt);
      idle($urandom_range(4, 40));
      if ($urandom_range(0, 2) == 0) pulse_clear();
      if ($urandom_range(0, 3) == 0) begin
        glitch($urandom_range(1, 100));
        idle(150);
      end
    end

    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    check16("final_out", out, model_out);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
